// File: rtl/sd_cmd_seq_if.sv
// Bundle between the SD command sequencer, its requester, the 48-bit command
// shifter and the MISO pin. The sequencer takes the slave side.
interface sd_cmd_seq_if;
  logic        req;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [1:0]  resp_type;
  logic        busy;
  logic        resp_valid;
  logic        timeout;
  logic [39:0] resp;
  logic        cs_n;
  logic        mosi_sel;
  logic        tx_send;
  logic [5:0]  tx_cmd;
  logic [31:0] tx_arg;
  logic        tx_done;
  logic        sd_in;

  modport slave (
    input  req, cmd, arg, resp_type, tx_done, sd_in,
    output busy, resp_valid, timeout, resp, cs_n, mosi_sel, tx_send, tx_cmd, tx_arg
  );

  modport master (
    output req, cmd, arg, resp_type, tx_done, sd_in,
    input  busy, resp_valid, timeout, resp, cs_n, mosi_sel, tx_send, tx_cmd, tx_arg
  );
endinterface

// File: rtl/sd_cmd_seq.sv
// SD SPI command transaction sequencer: chip select, lead-in, shifter trigger,
// response polling and capture. Define SD_BUSY_WAIT_EN to build R1b busy wait.
module sd_cmd_seq #(
  parameter int unsigned LEAD_BITS  = 8,
  parameter int unsigned TRAIL_BITS = 8,
  parameter int unsigned NCR_MAX    = 64,
  parameter int unsigned BUSY_MAX   = 65535
) (
  input  logic        clock,
  input  logic        reset,
  sd_cmd_seq_if.slave bus
);

  localparam int unsigned MAX_A   = (NCR_MAX > BUSY_MAX) ? NCR_MAX : BUSY_MAX;
  localparam int unsigned MAX_B   = (MAX_A > LEAD_BITS) ? MAX_A : LEAD_BITS;
  localparam int unsigned MAX_C   = (MAX_B > TRAIL_BITS) ? MAX_B : TRAIL_BITS;
  localparam int unsigned CNT_MAX = (MAX_C > 40) ? MAX_C : 40;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'(LEAD_BITS - 1);
  localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(TRAIL_BITS - 1);
  localparam logic [CNT_W-1:0] NCR_LOAD   = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] R1_LOAD    = CNT_W'(7);
  localparam logic [CNT_W-1:0] R3_LOAD    = CNT_W'(39);
`ifdef SD_BUSY_WAIT_EN
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_MAX - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD,
    S_SEND,
    S_WAIT_TX,
    S_POLL,
    S_RECV,
`ifdef SD_BUSY_WAIT_EN
    S_BUSY,
`endif
    S_TRAIL,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0] resp_q, resp_d;
  logic        long_q, long_d;
  logic        tout_q, tout_d;
  logic [5:0]  tx_cmd_q, tx_cmd_d;
  logic [31:0] tx_arg_q, tx_arg_d;
`ifdef SD_BUSY_WAIT_EN
  logic        r1b_q, r1b_d;
`endif
  logic        cs_n_q, cs_n_d;
  logic        mosi_sel_q, mosi_sel_d;
  logic        tx_send_q, tx_send_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    // NOTE: every _d gets a hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    long_d   = long_q;
    tout_d   = tout_q;
    tx_cmd_d = tx_cmd_q;
    tx_arg_d = tx_arg_q;
`ifdef SD_BUSY_WAIT_EN
    r1b_d    = r1b_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          tx_cmd_d = bus.cmd;
          tx_arg_d = bus.arg;
          long_d   = (bus.resp_type == 2'd2);
`ifdef SD_BUSY_WAIT_EN
          r1b_d    = (bus.resp_type == 2'd1);
`endif
          resp_d   = '0;
          tout_d   = 1'b0;
          cnt_d    = LEAD_LOAD;
          state_d  = S_LEAD;
        end
      end
      S_LEAD: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.tx_done) begin
          cnt_d   = NCR_LOAD;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (!bus.sd_in) begin
          resp_d  = {resp_q[38:0], 1'b0};
          cnt_d   = long_q ? R3_LOAD : R1_LOAD;
          state_d = S_RECV;
        end else if (cnt_q == '0) begin
          // Card never answered: report an all-ones response of the expected length.
          resp_d  = long_q ? {40{1'b1}} : 40'hFF;
          tout_d  = 1'b1;
          cnt_d   = TRAIL_LOAD;
          state_d = S_TRAIL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECV: begin
        resp_d = {resp_q[38:0], bus.sd_in};
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = TRAIL_LOAD;
          state_d = S_TRAIL;
`ifdef SD_BUSY_WAIT_EN
          if (r1b_q) begin
            cnt_d   = BUSY_LOAD;
            state_d = S_BUSY;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SD_BUSY_WAIT_EN
      S_BUSY: begin
        if (bus.sd_in) begin
          cnt_d   = TRAIL_LOAD;
          state_d = S_TRAIL;
        end else if (cnt_q == '0) begin
          tout_d  = 1'b1;
          cnt_d   = TRAIL_LOAD;
          state_d = S_TRAIL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_TRAIL: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cs_n_d       = (state_d == S_IDLE) || (state_d == S_DONE);
    mosi_sel_d   = (state_d == S_SEND) || (state_d == S_WAIT_TX);
    tx_send_d    = (state_d == S_SEND);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    timeout_d    = (state_d == S_DONE) && tout_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resp_q       <= '0;
      long_q       <= 1'b0;
      tout_q       <= 1'b0;
      tx_cmd_q     <= '0;
      tx_arg_q     <= '0;
`ifdef SD_BUSY_WAIT_EN
      r1b_q        <= 1'b0;
`endif
      cs_n_q       <= 1'b1;
      mosi_sel_q   <= 1'b0;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      long_q       <= long_d;
      tout_q       <= tout_d;
      tx_cmd_q     <= tx_cmd_d;
      tx_arg_q     <= tx_arg_d;
`ifdef SD_BUSY_WAIT_EN
      r1b_q        <= r1b_d;
`endif
      cs_n_q       <= cs_n_d;
      mosi_sel_q   <= mosi_sel_d;
      tx_send_q    <= tx_send_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.resp       = resp_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.mosi_sel   = mosi_sel_q;
  assign bus.tx_send    = tx_send_q;
  assign bus.tx_cmd     = tx_cmd_q;
  assign bus.tx_arg     = tx_arg_q;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Directed bench for sd_cmd_seq with a 48-cycle command shifter model and a
// scripted card on MISO. Cycle rel=1 is the first cycle after req is accepted.
module tb_sd_cmd_seq;

  localparam int LEAD     = 8;
  localparam int TRAIL    = 8;
  localparam int NCR      = 64;
  localparam int POLL_REL = LEAD + 1 + 48 + 1;
  localparam int MAXC     = 300;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sd_cmd_seq_if bus ();

  sd_cmd_seq #(
    .LEAD_BITS (LEAD),
    .TRAIL_BITS(TRAIL),
    .NCR_MAX   (NCR),
    .BUSY_MAX  (65535)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Shifter model: loads on send, done is low for 47 cycles then high again.
  logic [5:0] sh_cnt;
  always @(posedge clock) begin
    if (reset)                sh_cnt <= 6'd0;
    else if (bus.tx_send)     sh_cnt <= 6'd47;
    else if (sh_cnt != 6'd0)  sh_cnt <= sh_cnt - 6'd1;
  end
  assign bus.tx_done = (sh_cnt == 6'd0);

  int tests = 0;
  int fails = 0;

  int          vld_cnt, vld_rel, cs_low, send_cnt, send_rel, busy_cyc, mosi_cnt, tout_stray;
  logic [39:0] obs_resp, resp_at1;
  logic        obs_tout;
  logic [5:0]  sent_cmd, end_cmd;
  logic [31:0] sent_arg;
  logic        rst_cs, rst_busy;
  logic [39:0] rst_resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic card_bit(input int rel, input logic [39:0] bits, input int len,
                                    input int delay, input int hold_to);
    int ps;
    ps = POLL_REL + delay;
    if (len == 0 || rel < ps) return 1'b1;
    if (rel < ps + len)        return bits[len - 1 - (rel - ps)];
    if (rel < hold_to)         return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_txn(input logic [5:0] c, input logic [31:0] a, input logic [1:0] rt,
                         input logic [39:0] bits, input int len, input int delay,
                         input int hold_to, input int inject_rel, input int rst_rel);
    vld_cnt = 0; vld_rel = -1; cs_low = 0; send_cnt = 0; send_rel = -1;
    busy_cyc = 0; mosi_cnt = 0; tout_stray = 0;
    obs_resp = '0; obs_tout = 1'b0; sent_cmd = '0; sent_arg = '0; end_cmd = '0;
    bus.req = 1'b1; bus.cmd = c; bus.arg = a; bus.resp_type = rt; bus.sd_in = 1'b1;
    tick();
    bus.req = 1'b0;
    for (int rel = 1; rel <= MAXC; rel++) begin
      if (rel == 1) resp_at1 = bus.resp;
      if (rel == rst_rel + 1) begin
        reset = 1'b0;
        rst_cs = bus.cs_n; rst_busy = bus.busy; rst_resp = bus.resp;
      end
      if (bus.resp_valid) begin
        vld_cnt++;
        if (vld_rel < 0) begin
          vld_rel = rel; obs_resp = bus.resp; obs_tout = bus.timeout; end_cmd = bus.tx_cmd;
        end
      end else if (bus.timeout) tout_stray++;
      if (!bus.cs_n)    cs_low++;
      if (bus.busy)     busy_cyc++;
      if (bus.mosi_sel) mosi_cnt++;
      if (bus.tx_send) begin
        send_cnt++; send_rel = rel; sent_cmd = bus.tx_cmd; sent_arg = bus.tx_arg;
      end
      if (vld_rel > 0 && rel == vld_rel + 1) break;
      bus.sd_in = card_bit(rel, bits, len, delay, hold_to);
      bus.req   = (rel == inject_rel);
      bus.cmd   = (rel == inject_rel) ? 6'd17 : c;
      if (rel == rst_rel) reset = 1'b1;
      tick();
    end
    bus.req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 1'b0; bus.cmd = '0; bus.arg = '0; bus.resp_type = '0; bus.sd_in = 1'b1;
    tick();
    tick();
    check("rst_cs_n",     64'(bus.cs_n), 64'd1);
    check("rst_mosi_sel", 64'(bus.mosi_sel), 64'd0);
    check("rst_tx_send",  64'(bus.tx_send), 64'd0);
    check("rst_busy",     64'(bus.busy), 64'd0);
    check("rst_valid",    64'({bus.resp_valid, bus.timeout}), 64'd0);
    check("rst_resp",     64'(bus.resp), 64'd0);
    check("rst_tx_regs",  64'({bus.tx_cmd, bus.tx_arg}), 64'd0);
    reset = 1'b0;
    tick();

    // R1, card answers 8'h01 on the 3rd poll bit.
    run_txn(6'd0, 32'd0, 2'd0, 40'h01, 8, 2, 0, -1, -5);
    check("r1_vld_cnt",  64'(vld_cnt), 64'd1);
    check("r1_vld_rel",  64'(vld_rel), 64'(POLL_REL + 2 + 8 + TRAIL));
    check("r1_resp",     64'(obs_resp), 64'h01);
    check("r1_timeout",  64'(obs_tout), 64'd0);
    check("r1_cs_low",   64'(cs_low), 64'(vld_rel - 1));
    check("r1_busy_cyc", 64'(busy_cyc), 64'(vld_rel));
    check("r1_send_cnt", 64'(send_cnt), 64'd1);
    check("r1_send_rel", 64'(send_rel), 64'(LEAD + 1));
    check("r1_tx_cmd",   64'(sent_cmd), 64'd0);
    check("r1_mosi_cnt", 64'(mosi_cnt), 64'd49);
    check("r1_tout_idle", 64'(tout_stray), 64'd0);

    // R7 accepted back-to-back in the first IDLE cycle.
    run_txn(6'd8, 32'h1AA, 2'd2, 40'h01_0000_01AA, 40, 0, 0, -1, -5);
    check("r7_resp_clr", 64'(resp_at1), 64'd0);
    check("r7_vld_rel",  64'(vld_rel), 64'(POLL_REL + 40 + TRAIL));
    check("r7_resp",     64'(obs_resp), 64'h01_0000_01AA);
    check("r7_timeout",  64'(obs_tout), 64'd0);
    check("r7_tx_args",  64'({sent_cmd, sent_arg}), 64'({6'd8, 32'h1AA}));

    // Best-case latency with resp_type 3 treated as R1.
    run_txn(6'd13, 32'h0, 2'd3, 40'h05, 8, 0, 0, -1, -5);
    check("rt3_latency", 64'(vld_rel), 64'd74);
    check("rt3_resp",    64'(obs_resp), 64'h05);

    // NCR timeout, R1 and R3 lengths.
    run_txn(6'd0, 32'd0, 2'd0, 40'h0, 0, 0, 0, -1, -5);
    check("ncr_r1_vld_rel", 64'(vld_rel), 64'(POLL_REL + NCR + TRAIL));
    check("ncr_r1_resp",    64'(obs_resp), 64'hFF);
    check("ncr_r1_timeout", 64'(obs_tout), 64'd1);
    check("ncr_r1_tidle",   64'(tout_stray), 64'd0);
    run_txn(6'd58, 32'd0, 2'd2, 40'h0, 0, 0, 0, -1, -5);
    check("ncr_r3_resp",    64'(obs_resp), 64'hFF_FFFF_FFFF);
    check("ncr_r3_timeout", 64'(obs_tout), 64'd1);

    // R1b: R1 8'h00, MISO low for 100 cycles counting the last R1 bit, then high.
    run_txn(6'd12, 32'd0, 2'd1, 40'h00, 8, 0, POLL_REL + 7 + 100, -1, -5);
`ifdef SD_BUSY_WAIT_EN
    check("r1b_vld_rel", 64'(vld_rel), 64'(POLL_REL + 7 + 100 + TRAIL + 1));
`else
    check("r1b_vld_rel", 64'(vld_rel), 64'(POLL_REL + 7 + TRAIL + 1));
`endif
    check("r1b_resp",    64'(obs_resp), 64'h00);
    check("r1b_timeout", 64'(obs_tout), 64'd0);

    // Reset after 3 response bits (0,1,1) during RECV.
    run_txn(6'd9, 32'd0, 2'd0, 40'h7F, 8, 0, 0, -1, POLL_REL + 3);
    check("rst_mid_cs_n", 64'(rst_cs), 64'd1);
    check("rst_mid_busy", 64'(rst_busy), 64'd0);
    check("rst_mid_resp", 64'(rst_resp), 64'd0);
    check("rst_mid_vld",  64'(vld_cnt), 64'd0);
    run_txn(6'd16, 32'h200, 2'd0, 40'h09, 8, 5, 0, -1, -5);
    check("post_rst_vld_rel", 64'(vld_rel), 64'(POLL_REL + 5 + 8 + TRAIL));
    check("post_rst_resp",    64'(obs_resp), 64'h09);

    // Second req during WAIT_TX is ignored and not queued.
    run_txn(6'd55, 32'd0, 2'd0, 40'h01, 8, 0, 0, 20, -5);
    check("inj_vld_cnt", 64'(vld_cnt), 64'd1);
    check("inj_vld_rel", 64'(vld_rel), 64'd74);
    check("inj_tx_cmd",  64'(end_cmd), 64'd55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("inj_no_queue", 64'({bus.busy, bus.cs_n}), 64'b01);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_cmd_seq.md
# sd_cmd_seq

Sequences one SD-card SPI command transaction around the existing 48-bit command shifter: asserts chip select, emits lead-in clocks, triggers the shifter, polls MISO for the response start bit, and shifts in an R1, R1b or R3/R7 response. It sits between the card-init / block-transfer logic (the requester) and the command shifter plus MISO pin. It owns `cs_n`, and it owns the pin mux select while a transaction is in flight.

## Interface
Parameters:
- `LEAD_BITS`, 8: clocks with `cs_n` low and MOSI idle (1) before the shifter is triggered.
- `TRAIL_BITS`, 8: clocks after the response (or busy release) before `cs_n` is raised.
- `NCR_MAX`, 64: maximum bit times spent polling for the response start bit.
- `BUSY_MAX`, 65535: maximum bit times spent waiting for busy release. Used only with `SD_BUSY_WAIT_EN`.

Ports:
- `clock` in 1: SPI bit clock domain. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: start a transaction. Sampled only in IDLE.
- `cmd` in 6: command index. Latched with `req`.
- `arg` in 32: command argument. Latched with `req`.
- `resp_type` in 2: 0 = R1 (8 bits), 1 = R1b, 2 = R3/R7 (40 bits), 3 = treated as R1.
- `busy` out 1: high from the cycle after an accepted `req` until the cycle after `resp_valid`.
- `resp_valid` out 1: one-cycle completion pulse.
- `timeout` out 1: qualifies `resp_valid`. High means no start bit was seen, or busy never released.
- `resp` out 40: response, right-aligned. R1 occupies [7:0] and [39:8] are 0. Held until the next accepted `req`.
- `cs_n` out 1: card chip select, active-low.
- `mosi_sel` out 1: 1 = MOSI driven by the shifter, 0 = MOSI forced high.
- `tx_send` out 1: one-cycle pulse to the shifter's `send`.
- `tx_cmd` out 6: latched `cmd` to the shifter.
- `tx_arg` out 32: latched `arg` to the shifter.
- `tx_done` in 1: shifter `done`.
- `sd_in` in 1: card MISO.

## Operation
State machine: IDLE → LEAD → SEND → WAIT_TX → POLL → RECV → [BUSY] → TRAIL → DONE → IDLE.

- **IDLE:** `cs_n`=1, `busy`=0. When `req`=1, latch `cmd`, `arg` and `resp_type`, clear `resp`, and go to LEAD. A `req` in any other state is ignored and is not queued.
- **LEAD:** `cs_n`=0, `mosi_sel`=0. Count `LEAD_BITS` cycles, then go to SEND.
- **SEND:** `tx_send`=1 for exactly this cycle, `mosi_sel`=1. Go to WAIT_TX.
- **WAIT_TX:** remain while `tx_done`=0. When `tx_done`=1, go to POLL. `tx_done` is already low in the first WAIT_TX cycle because the shifter loads its count on `tx_send`.
- **POLL:** `mosi_sel`=0 and a bit counter runs.
  - `sd_in`=0: shift 0 into `resp`, set the remaining count to len−1 (7 or 39), and go to RECV.
  - `NCR_MAX` cycles pass with `sd_in`=1: set `resp` = 40'hFF_FFFF_FFFF (R1 gives 40'h00_0000_00FF), set the timeout flag, and go to TRAIL.
- **RECV:** shift `sd_in` into the `resp` LSB each cycle, MSB first. After the last bit:
  - R1b with the macro enabled: go to BUSY.
  - Otherwise: go to TRAIL.
- **BUSY:** remain while `sd_in`=0.
  - `sd_in`=1: go to TRAIL.
  - `BUSY_MAX` cycles elapse: set the timeout flag and go to TRAIL. `resp` keeps the received R1.
- **TRAIL:** `cs_n`=0, `mosi_sel`=0. Count `TRAIL_BITS` cycles, then go to DONE.
- **DONE:** `cs_n`=1, `resp_valid`=1, and `timeout` = timeout flag. Go to IDLE.

Counter rules:
- One shared counter, width ≥ clog2(max(`NCR_MAX`, `BUSY_MAX`, `LEAD_BITS`, 40)) + 1.
- It reloads on every state entry and never wraps.

## Timing
- Reset values: `cs_n`=1, `mosi_sel`=0, `tx_send`=0, `busy`=0, `resp_valid`=0, `timeout`=0, `resp`=0, `tx_cmd`=0, `tx_arg`=0, state IDLE.
- Reset asserted mid-transaction: the next edge forces IDLE and the reset values, and no `resp_valid` is emitted. The shifter is reset by the same `reset`.
- `req` is accepted at edge 0:
  - LEAD occupies cycles 1..`LEAD_BITS`.
  - `tx_send` is high in cycle `LEAD_BITS`+1.
  - POLL is entered in the cycle after the shifter's `done` returns high.
- Best-case R1 latency, card answering on the first poll bit: `req` → `resp_valid` = `LEAD_BITS` + 1 + 48 + 8 + `TRAIL_BITS` + 1 cycles (74 with defaults).
- `timeout` is meaningful only while `resp_valid`=1, and is 0 otherwise.
- Back-to-back: a new `req` may be accepted in the first IDLE cycle, which is the cycle after `resp_valid`.

## Configuration
- **`SD_BUSY_WAIT_EN` defined:** the BUSY state and `BUSY_MAX` logic are built. R1b waits for `sd_in` high before TRAIL.
- **`SD_BUSY_WAIT_EN` undefined:** BUSY is not built. R1b behaves exactly like R1, and `timeout` is raised only by an NCR timeout.

## Test plan
- **R1, normal:** `cmd`=0, `arg`=0, `resp_type`=0. Card returns 8'h01 on the 3rd poll bit → one `resp_valid`, `resp`=40'h01, `timeout`=0, `cs_n` low for exactly the transaction, and `tx_send` high for 1 cycle with `tx_cmd`=0.
- **R7:** `cmd`=8, `arg`=32'h1AA, `resp_type`=2. Card returns 40'h01_0000_01AA → `resp`=40'h01000001AA, `timeout`=0.
- **NCR timeout:** `sd_in` held 1, `resp_type`=0 → `resp_valid` with `timeout`=1 and `resp`=40'hFF, exactly `NCR_MAX` poll cycles after POLL entry.
- **R1b busy** (macro on): R1 8'h00, then `sd_in`=0 for 100 cycles, then 1 → `resp_valid` `TRAIL_BITS`+1 cycles after release, `timeout`=0. The same stimulus with the macro off → `resp_valid` 100 cycles earlier.
- **Reset in RECV:** pulse `reset` after 3 response bits → next cycle `cs_n`=1, `busy`=0, `resp`=0, and no `resp_valid`. A following `req` completes normally.
- **`req` while busy:** a second `req` during WAIT_TX with `cmd`=17 → ignored, and `tx_cmd` stays at the first command.
